// File: rtl/alu_pkg.sv
// Shared constants and types for the round-robin ALU scheduler and its ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } sched_state_e;

  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: first valid requester after ptr_i, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GRANT_W = 2
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [GRANT_W-1:0] grant_idx_o,
  output logic               any_o
);

  logic [GRANT_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    // Search starts one past the last winner so that winner has lowest priority.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = GRANT_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!any_o && req_valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among NUM_REQ requesters with round-robin arbitration.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = alu_pkg::DATA_W,
  parameter int unsigned OPC_W   = alu_pkg::OPC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*OPC_W-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]          rsp_result,
  output logic                       rsp_error,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [OPC_W-1:0]           alu_opcode,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic                       alu_error
);

  localparam int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e       state_q;
  logic [GRANT_W-1:0] ptr_q;
  logic [GRANT_W-1:0] grant_q;
  logic [NUM_REQ-1:0] grant_oh_q;
  logic [DATA_W-1:0]  alu_a_q;
  logic [DATA_W-1:0]  alu_b_q;
  logic [OPC_W-1:0]   alu_op_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic               rsp_error_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [GRANT_W-1:0] arb_idx;
  logic               arb_any;
  logic               rsp_hs;

  logic [DATA_W-1:0]  a_arr  [NUM_REQ];
  logic [DATA_W-1:0]  b_arr  [NUM_REQ];
  logic [OPC_W-1:0]   op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = req_opcode[g*OPC_W +: OPC_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_arb (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE) begin
      req_ready = arb_grant;
    end
  end

  // Only the granted requester's rsp_ready can complete the response.
  assign rsp_hs = |(rsp_valid_q & rsp_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= GRANT_W'(NUM_REQ - 1);
      grant_q      <= '0;
      grant_oh_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            alu_a_q    <= a_arr[arb_idx];
            alu_b_q    <= b_arr[arb_idx];
            alu_op_q   <= op_arr[arb_idx];
            grant_q    <= arb_idx;
            grant_oh_q <= arb_grant;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          rsp_result_q <= alu_result;
          rsp_error_q  <= alu_error;
          rsp_valid_q  <= grant_oh_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            ptr_q       <= grant_q;
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural 1-cycle registered ALU.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [NR*OW-1:0]  req_opcode;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [DW-1:0]     rsp_result;
  logic              rsp_error;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [OW-1:0]     alu_opcode;
  logic [DW-1:0]     alu_result;
  logic              alu_error;

  logic [DW-1:0]     ta  [NR];
  logic [DW-1:0]     tbv [NR];
  logic [OW-1:0]     top [NR];

  int tests;
  int fails;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_a[g*DW +: DW]      = ta[g];
    assign req_b[g*DW +: DW]      = tbv[g];
    assign req_opcode[g*OW +: OW] = top[g];
  end

  alu_rr_scheduler #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .OPC_W   (OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_error  (alu_error)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      alu_result <= '0;
      alu_error  <= 1'b0;
    end else begin
      alu_error <= !is_legal_op(alu_opcode);
      case (alu_opcode)
        3'b000:  alu_result <= alu_a + alu_b;
        3'b001:  alu_result <= alu_a - alu_b;
        3'b010:  alu_result <= alu_a & alu_b;
        3'b011:  alu_result <= alu_a | alu_b;
        3'b100:  alu_result <= alu_a ^ alu_b;
        default: alu_result <= '0;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]    idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic [DW-1:0] res;
    logic          err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, output logic [NR-1:0] got);
    got = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready != '0) begin
        got = req_ready;
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for req_ready, got %b expected nonzero", name, req_ready);
  endtask

  task automatic wait_rsp(input string name, output logic [NR-1:0] got);
    got = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rsp_valid != '0) begin
        got = rsp_valid;
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for rsp_valid, got %b expected nonzero", name, rsp_valid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_rsp_error", rsp_error, '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);
    chk("rst_alu_opcode", alu_opcode, '0);
  endtask

  task automatic do_op(input string name, input vec_t v);
    logic [NR-1:0] got;
    logic [NR-1:0] oh;
    oh = 4'b0001 << v.idx;
    ta[v.idx]  = v.a;
    tbv[v.idx] = v.b;
    top[v.idx] = v.op;
    req_valid[v.idx] = 1'b1;
    wait_ready({name, "_ready"}, got);
    chk({name, "_ready"}, got, oh);
    @(posedge clk);
    #1;
    req_valid[v.idx] = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, rsp_valid, '0);
    @(negedge clk);
    chk({name, "_lat2"}, rsp_valid, '0);
    @(negedge clk);
    chk({name, "_valid"}, rsp_valid, oh);
    chk({name, "_result"}, rsp_result, v.res);
    chk({name, "_error"}, rsp_error, v.err);
    chk({name, "_alu_op"}, alu_opcode, v.op);
    rsp_ready[v.idx] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[v.idx] = 1'b0;
    chk({name, "_clear"}, rsp_valid, '0);
    chk({name, "_alu_hold"}, alu_a, v.a);
  endtask

  initial begin
    logic [NR-1:0] got;
    logic [NR-1:0] exp_oh;
    logic [DW-1:0] xa [NR];
    logic [DW-1:0] xb [NR];
    logic [DW-1:0] xr [NR];

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NR; i++) begin
      ta[i] = '0; tbv[i] = '0; top[i] = '0;
    end

    vecs[0] = '{2'd0, 32'd5,          32'd3,          OP_ADD, 32'd8,          1'b0};
    vecs[1] = '{2'd1, 32'd10,         32'd4,          OP_SUB, 32'd6,          1'b0};
    vecs[2] = '{2'd2, 32'd7,          32'd9,          3'b101, 32'd0,          1'b1};
    vecs[3] = '{2'd3, 32'd0,          32'd1,          OP_SUB, 32'hFFFF_FFFF,  1'b0};
    vecs[4] = '{2'd0, 32'hFFFF_FFFF,  32'd1,          OP_ADD, 32'd0,          1'b0};
    vecs[5] = '{2'd1, 32'hF0F0_1234,  32'h0FF0_FF00,  OP_AND, 32'h00F0_1200,  1'b0};
    vecs[6] = '{2'd2, 32'hA000_0005,  32'h0500_0050,  OP_OR,  32'hA500_0055,  1'b0};
    vecs[7] = '{2'd3, 32'h1234_5678,  32'hFFFF_0000,  OP_XOR, 32'hEDCB_5678,  1'b0};
    vecs[8] = '{2'd1, 32'd1,          32'd2,          3'b111, 32'd0,          1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // All four requesters contend straight after reset: order must be 0,1,2,3.
    xa[0] = 32'h00FF_00FF; xb[0] = 32'h0F0F_0F0F; xr[0] = 32'h0FF0_0FF0;
    xa[1] = 32'h1234_5678; xb[1] = 32'h0000_0000; xr[1] = 32'h1234_5678;
    xa[2] = 32'hFFFF_FFFF; xb[2] = 32'h0000_FFFF; xr[2] = 32'hFFFF_0000;
    xa[3] = 32'hAAAA_AAAA; xb[3] = 32'h5555_5555; xr[3] = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      ta[i] = xa[i]; tbv[i] = xb[i]; top[i] = OP_XOR;
    end
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < NR; k++) begin
      exp_oh = 4'b0001 << k;
      wait_ready("rr4_grant", got);
      chk("rr4_grant", got, exp_oh);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      wait_rsp("rr4_rsp", got);
      chk("rr4_rsp_valid", got, exp_oh);
      chk("rr4_result", rsp_result, xr[k]);
    end
    @(posedge clk);
    #1;
    rsp_ready = '0;

    // Response back-pressure with another requester waiting.
    ta[1] = 32'd10; tbv[1] = 32'd4; top[1] = OP_SUB;
    ta[3] = 32'd1;  tbv[3] = 32'd2; top[3] = OP_ADD;
    req_valid[1] = 1'b1;
    wait_ready("bp_grant1", got);
    chk("bp_grant1", got, 4'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_valid[3] = 1'b1;
    wait_rsp("bp_rsp1", got);
    chk("bp_rsp1_valid", got, 4'b0010);
    chk("bp_rsp1_result", rsp_result, 32'd6);
    rsp_ready[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 4'b0010);
      chk("bp_hold_result", rsp_result, 32'd6);
      chk("bp_hold_error", rsp_error, 1'b0);
      chk("bp_hold_ready", req_ready, '0);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b0;
    chk("bp_after_hs_valid", rsp_valid, '0);
    chk("bp_after_hs_ready3", req_ready, 4'b1000);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    wait_rsp("bp_rsp3", got);
    chk("bp_rsp3_valid", got, 4'b1000);
    chk("bp_rsp3_result", rsp_result, 32'd3);
    @(posedge clk);
    #1;
    rsp_ready = '0;

    // Reset while req1's operation is in CAPTURE.
    ta[1] = 32'd20; tbv[1] = 32'd22; top[1] = OP_ADD;
    req_valid[1] = 1'b1;
    wait_ready("rc_grant1", got);
    chk("rc_grant1", got, 4'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rc_capture_alu_a", alu_a, 32'd20);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rc_req_ready", req_ready, '0);
    chk("rc_rsp_valid", rsp_valid, '0);
    chk("rc_rsp_result", rsp_result, '0);
    chk("rc_rsp_error", rsp_error, '0);
    chk("rc_alu_a", alu_a, '0);
    chk("rc_alu_b", alu_b, '0);
    chk("rc_alu_opcode", alu_opcode, '0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rc_no_rsp", rsp_valid, '0);
    end
    ta[0] = 32'd1;    tbv[0] = 32'd1;    top[0] = OP_ADD;
    ta[2] = 32'h0F0F; tbv[2] = 32'h00FF; top[2] = OP_AND;
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    rsp_ready = '1;
    wait_ready("rc_next_grant", got);
    chk("rc_next_grant", got, 4'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_rsp("rc_rsp0", got);
    chk("rc_rsp0_valid", got, 4'b0001);
    chk("rc_rsp0_result", rsp_result, 32'd2);
    wait_ready("rc_grant2", got);
    chk("rc_grant2", got, 4'b0100);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wait_rsp("rc_rsp2", got);
    chk("rc_rsp2_valid", got, 4'b0100);
    chk("rc_rsp2_result", rsp_result, 32'h000F);
    @(posedge clk);
    #1;
    rsp_ready = '0;

    // Two persistent requesters alternate.
    do_reset();
    ta[0] = 32'd100;  tbv[0] = 32'd23;  top[0] = OP_ADD;
    ta[2] = 32'h00F0; tbv[2] = 32'h000F; top[2] = OP_OR;
    req_valid = 4'b0101;
    rsp_ready = '1;
    for (int k = 0; k < 8; k++) begin
      exp_oh = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      wait_ready("alt_grant", got);
      chk("alt_grant", got, exp_oh);
      @(posedge clk);
      wait_rsp("alt_rsp", got);
      chk("alt_rsp_valid", got, exp_oh);
      chk("alt_result", rsp_result, (k % 2 == 0) ? 32'd123 : 32'h00FF);
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
